// File: rtl/lsu_subword.sv
// lsu_subword: RV32I load/store unit between the execute stage and a
// word-addressed data memory. Loads are aligned and extended with zero
// latency; SW writes in the same cycle; SB/SH are a two-cycle
// read-modify-write that stalls the core during the read cycle.
// Misaligned, out-of-range and illegal-funct3 accesses raise o_fault and
// are suppressed.
// Optional build macro: LSU_PERF_EN adds the o_rmw_cnt / o_fault_cnt
// performance counters.
module lsu_subword #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_stall,
    output logic        o_fault,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
`ifdef LSU_PERF_EN
   ,output logic [31:0] o_rmw_cnt,
    output logic [31:0] o_fault_cnt
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // RV32I funct3 width/sign codes
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Word-index limit, sized to compare directly with i_addr[31:2]
    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] merge_q;

    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        fault_det;
    logic        rmw_start;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Decode the fault conditions for the request presented in IDLE
    always_comb begin
        // NOTE: every signal written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (i_we) begin
            illegal = !(i_funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal = !(i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        end
        case (i_funct3)
            F3_H, F3_HU: misaligned = i_addr[0];
            F3_W:        misaligned = (i_addr[1:0] != 2'b00);
            default:     misaligned = 1'b0;
        endcase
        out_of_range = (i_addr[31:2] >= MEM_WORDS_W);
        fault_det    = i_req && (state == ST_IDLE)
                       && (illegal || misaligned || out_of_range);
        rmw_start    = i_req && (state == ST_IDLE) && !fault_det
                       && i_we && (i_funct3 != F3_W);
    end

    // Select and extend the addressed lane of the memory word for loads
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = 32'h0000_0000;
        case (i_addr[1:0])
            2'd0:    byte_sel = i_mem_rdata[7:0];
            2'd1:    byte_sel = i_mem_rdata[15:8];
            2'd2:    byte_sel = i_mem_rdata[23:16];
            default: byte_sel = i_mem_rdata[31:24];
        endcase
        half_sel = i_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
        case (i_funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = i_mem_rdata;
            F3_BU:   load_data = {24'h000000, byte_sel};
            F3_HU:   load_data = {16'h0000, half_sel};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Insert the store lane into the old word; other bytes keep memory value
    always_comb begin
        merged = i_mem_rdata;
        if (i_funct3 == F3_B) begin
            merged[{i_addr[1:0], 3'b000} +: 8] = i_wdata[7:0];
        end else begin
            merged[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
        end
    end

    // Drive the core and memory sides from the current state and request
    always_comb begin
        o_stall     = 1'b0;
        o_fault     = 1'b0;
        o_mem_we    = 1'b0;
        o_rdata     = 32'h0000_0000;
        o_mem_addr  = {i_addr[31:2], 2'b00};
        o_mem_wdata = i_wdata;
        if (state == ST_WRITE) begin
            // Core inputs are held stable but ignored during the write cycle
            o_mem_addr  = addr_q;
            o_mem_wdata = merge_q;
            o_mem_we    = 1'b1;
        end else if (i_req) begin
            if (fault_det) begin
                o_fault = 1'b1;
            end else if (!i_we) begin
                o_rdata = load_data;
            end else if (i_funct3 == F3_W) begin
                o_mem_we = 1'b1;
            end else begin
                o_stall = 1'b1;
            end
        end
    end

    // RMW sequencer: capture the merged word in IDLE, write it in WRITE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= 32'h0000_0000;
            merge_q <= 32'h0000_0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rmw_start) begin
                        merge_q <= merged;
                        addr_q  <= {i_addr[31:2], 2'b00};
                        state   <= ST_WRITE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LSU_PERF_EN
    // Count completed RMW writes and faulting request cycles (wrapping)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rmw_cnt   <= 32'h0000_0000;
            o_fault_cnt <= 32'h0000_0000;
        end else begin
            if (state == ST_WRITE) begin
                o_rmw_cnt <= o_rmw_cnt + 32'd1;
            end
            if (i_req && o_fault) begin
                o_fault_cnt <= o_fault_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lsu_subword.sv
// tb_lsu_subword: directed bench for lsu_subword with a small behavioural
// data memory (combinational read, write on the rising edge).
module tb_lsu_subword;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        fault;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
`ifdef LSU_PERF_EN
    logic [31:0] rmw_cnt;
    logic [31:0] fault_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Data memory: 256 words, plus a bench-side preload port
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    lsu_subword #(.MEM_WORDS(256)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_we        (we),
        .i_funct3    (funct3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_rdata     (rdata),
        .o_stall     (stall),
        .o_fault     (fault),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
`ifdef LSU_PERF_EN
       ,.o_rmw_cnt   (rmw_cnt),
        .o_fault_cnt (fault_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        req    = r;
        we     = w;
        funct3 = f;
        addr   = a;
        wdata  = d;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        pre_idx  = idx;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        pre_we   = 1'b0;
        pre_idx  = 8'h00;
        pre_data = 32'h0;
        drive(1'b0, 1'b0, 3'd0, 32'h13, 32'h0);

        // Reset state with no request
        #2;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr", mem_addr, 32'h10);
`ifdef LSU_PERF_EN
        check("rst_rmw_cnt", rmw_cnt, 32'd0);
        check("rst_fault_cnt", fault_cnt, 32'd0);
`endif
        #10 rst_n = 1'b1;

        preload(8'd4, 32'h8899AABB);
        preload(8'd12, 32'h11223344);

        // Loads from word 0x10
        drive(1'b1, 1'b0, 3'd0, 32'h11, 32'h0); #2;
        check("lb_11", rdata, 32'hFFFFFFAA);
        check("lb_stall", {31'b0, stall}, 32'd0);
        drive(1'b1, 1'b0, 3'd4, 32'h11, 32'h0); #2;
        check("lbu_11", rdata, 32'h000000AA);
        drive(1'b1, 1'b0, 3'd1, 32'h12, 32'h0); #2;
        check("lh_12", rdata, 32'hFFFF8899);
        drive(1'b1, 1'b0, 3'd5, 32'h10, 32'h0); #2;
        check("lhu_10", rdata, 32'h0000AABB);
        drive(1'b1, 1'b0, 3'd0, 32'h13, 32'h0); #2;
        check("lb_13", rdata, 32'hFFFFFF88);
        drive(1'b1, 1'b0, 3'd2, 32'h10, 32'h0); #2;
        check("lw_10", rdata, 32'h8899AABB);
        check("lw_we", {31'b0, mem_we}, 32'd0);
        tick();

        // SW writes in the same cycle without stall
        drive(1'b1, 1'b1, 3'd2, 32'h20, 32'hDEADBEEF); #2;
        check("sw_we", {31'b0, mem_we}, 32'd1);
        check("sw_stall", {31'b0, stall}, 32'd0);
        check("sw_wdata", mem_wdata, 32'hDEADBEEF);
        check("sw_addr", mem_addr, 32'h20);
        tick();
        drive(1'b1, 1'b0, 3'd2, 32'h20, 32'h0); #2;
        check("lw_20", rdata, 32'hDEADBEEF);
        tick();

        // SB lane 1 as two-cycle read-modify-write
        drive(1'b1, 1'b1, 3'd0, 32'h21, 32'h12345677); #2;
        check("sb_c1_stall", {31'b0, stall}, 32'd1);
        check("sb_c1_we", {31'b0, mem_we}, 32'd0);
        tick(); #1;
        check("sb_c2_we", {31'b0, mem_we}, 32'd1);
        check("sb_c2_stall", {31'b0, stall}, 32'd0);
        check("sb_c2_wdata", mem_wdata, 32'hDEAD77EF);
        check("sb_c2_addr", mem_addr, 32'h20);
        tick();

        // SH upper half straight after, sees the SB result
        drive(1'b1, 1'b1, 3'd1, 32'h22, 32'h0000CAFE); #2;
        check("sh_c1_stall", {31'b0, stall}, 32'd1);
        tick(); #1;
        check("sh_c2_we", {31'b0, mem_we}, 32'd1);
        check("sh_c2_wdata", mem_wdata, 32'hCAFE77EF);
        tick();
        drive(1'b1, 1'b0, 3'd2, 32'h20, 32'h0); #2;
        check("lw_after_rmw", rdata, 32'hCAFE77EF);
        tick();

        // Faults: misaligned, out of range, illegal funct3
        drive(1'b1, 1'b0, 3'd2, 32'h22, 32'h0); #2;
        check("lw_mis_fault", {31'b0, fault}, 32'd1);
        check("lw_mis_rdata", rdata, 32'h0);
        check("lw_mis_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b1, 1'b1, 3'd1, 32'h13, 32'hFFFF); #2;
        check("sh_mis_fault", {31'b0, fault}, 32'd1);
        check("sh_mis_we", {31'b0, mem_we}, 32'd0);
        check("sh_mis_stall", {31'b0, stall}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 3'd1, 32'h401, 32'h0); #2;
        check("lh_oor_fault", {31'b0, fault}, 32'd1);
        check("lh_oor_rdata", rdata, 32'h0);
        tick();
        drive(1'b1, 1'b0, 3'd3, 32'h10, 32'h0); #2;
        check("f3_3_fault", {31'b0, fault}, 32'd1);
        check("f3_3_rdata", rdata, 32'h0);
        tick();
        drive(1'b1, 1'b1, 3'd4, 32'h10, 32'h0); #2;
        check("sbu_fault", {31'b0, fault}, 32'd1);
        check("sbu_we", {31'b0, mem_we}, 32'd0);
        tick();
        // Last in-range word is accepted
        drive(1'b1, 1'b0, 3'd2, 32'h3FC, 32'h0); #2;
        check("lw_3fc_fault", {31'b0, fault}, 32'd0);
        tick();

        // Reset asserted during WRITE abandons the store
        drive(1'b1, 1'b1, 3'd0, 32'h30, 32'h000000AA); #2;
        check("rw_c1_stall", {31'b0, stall}, 32'd1);
        tick(); #1;
        check("rw_c2_we", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_rst_we", {31'b0, mem_we}, 32'd0);
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rw_mem_kept", mem[12], 32'h11223344);
`ifdef LSU_PERF_EN
        check("rw_rmw_cnt0", rmw_cnt, 32'd0);
        check("rw_fault_cnt0", fault_cnt, 32'd0);
`endif
        drive(1'b1, 1'b0, 3'd2, 32'h30, 32'h0); #2;
        check("rw_lw_30", rdata, 32'h11223344);
        check("rw_idle_stall", {31'b0, stall}, 32'd0);
        check("rw_idle_addr", mem_addr, 32'h30);
        tick();

`ifdef LSU_PERF_EN
        // Three SB stores and two faults
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 3'd0, 32'h30 + 32'(i), 32'h55);
            tick();
            tick();
        end
        drive(1'b1, 1'b0, 3'd2, 32'h31, 32'h0);
        tick();
        drive(1'b1, 1'b0, 3'd7, 32'h30, 32'h0);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'h30, 32'h0); #2;
        check("perf_rmw_cnt", rmw_cnt, 32'd3);
        check("perf_fault_cnt", fault_cnt, 32'd2);
        rst_n = 1'b0;
        #1;
        check("perf_rmw_rst", rmw_cnt, 32'd0);
        check("perf_fault_rst", fault_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_subword.md
Name: lsu_subword

Overview:
- Load/store unit between the single-cycle core's execute stage and the word-addressed data memory.
- Turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Aligns and sign/zero-extends load data.
- Performs byte/halfword stores as a two-cycle read-modify-write, stalling the core during the first cycle.
- Flags misaligned and out-of-range accesses.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the data memory; byte addresses at or above 4*MEM_WORDS are out of range.

Ports:
- i_clk  input  1  system clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_req  input  1  core requests a memory access this cycle
- i_we  input  1  1 = store, 0 = load (valid with i_req)
- i_funct3  input  3  RV32I width/sign code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- i_addr  input  32  byte address from ALU
- i_wdata  input  32  store data (rs2); low byte/half used for SB/SH
- o_rdata  output  32  extended load result to writeback mux
- o_stall  output  1  hold PC and pipeline state this cycle
- o_fault  output  1  misaligned, out-of-range or illegal funct3; access suppressed
- o_mem_we  output  1  data memory write enable
- o_mem_addr  output  32  byte address to data memory (low 2 bits forced 0)
- i_mem_rdata  input  32  combinational read data from data memory at o_mem_addr

Behaviour:
- Clock/reset: one clock i_clk; reset i_rst_n asynchronous, active-low.
- State machine: IDLE and WRITE, plus registers addr_q[31:0] and merge_q[31:0].
- Reset: state=IDLE, addr_q=0, merge_q=0.
  - With i_req=0: o_stall=0, o_fault=0, o_mem_we=0, o_rdata=0, o_mem_addr={i_addr[31:2],2'b00}.
- Fault checks (combinational, in IDLE):
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - Out of range: i_addr[31:2] >= MEM_WORDS.
  - Illegal: funct3 in {3,6,7}, or store with funct3 in {4,5}.
  - Any fault: o_fault=1, o_mem_we=0, o_rdata=0, o_stall=0, state unchanged.
- Loads: zero latency, no stall.
  - Byte select uses addr[1:0]; halfword select uses addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
- SW (aligned, in range): o_mem_we=1 in the same cycle, o_mem_wdata=i_wdata, no stall.
- SB/SH cycle 1, in IDLE:
  - Outputs: o_stall=1, o_mem_we=0.
  - Computation: merge the selected lane of i_wdata into i_mem_rdata.
  - Clock edge: merge_q <= merged word, addr_q <= word address, state -> WRITE.
- SB/SH cycle 2, in WRITE:
  - Outputs: o_mem_addr=addr_q, o_mem_wdata=merge_q, o_mem_we=1, o_stall=0, o_fault=0.
  - Clock edge: state -> IDLE.
  - Core inputs are ignored in WRITE; the core holds them stable during the stall by contract.
- Lane merge: untouched bytes keep the exact old memory value.
- Back-to-back subword stores: each costs exactly 2 cycles.
  - A store to the same word immediately after the first sees the first store's written data, because the memory updates at the end of WRITE.
- Reset asserted in WRITE: the write is abandoned, state returns to IDLE asynchronously, and o_mem_we drops immediately.
- o_mem_wdata outside WRITE: equals i_wdata (don't-care when o_mem_we=0).

Optional Feature:
- Macro: LSU_PERF_EN.
- Defined: adds output o_rmw_cnt[31:0] and output o_fault_cnt[31:0].
  - o_rmw_cnt increments on each completed WRITE cycle.
  - o_fault_cnt increments on each cycle with i_req=1 and o_fault=1.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Mem word 0x10 = 0x8899AABB; LB @0x11 -> o_rdata=0xFFFFFFAA; LBU @0x11 -> 0x000000AA; LH @0x12 -> 0xFFFF8899; no stall.
- SW 0xDEADBEEF @0x20 -> o_mem_we=1 in the same cycle, o_stall=0; a subsequent LW @0x20 -> 0xDEADBEEF.
- Mem 0x20 = 0xDEADBEEF; SB 0x12345677 @0x21 -> cycle 1: o_stall=1, we=0; cycle 2: we=1, wdata=0xDEAD77EF; then SH 0xCAFE @0x22 -> 0xCAFE77EF.
- LW @0x22, SH @0x13, LH @0x401 with MEM_WORDS=256, funct3=3 -> o_fault=1, we=0, o_rdata=0, no stall.
- Start SB, assert i_rst_n=0 during WRITE -> o_mem_we=0 immediately, memory word unchanged, state IDLE after release.
- With LSU_PERF_EN: three SB stores plus two faults -> o_rmw_cnt=3, o_fault_cnt=2; both return to 0 after reset.
